// File: rtl/fifo_pixel_writer.sv
// fifo_pixel_writer: pulls byte pairs from the SD-reader FIFO (first byte is the MSB),
// forms RGB565 pixels and writes them to consecutive framebuffer addresses.
module fifo_pixel_writer #(
    parameter int FRAME_PIXELS = 76800,
    parameter int ADDR_WIDTH   = 17
) (
    input  logic                  SCLK,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  clear,
    input  logic                  fifo_empty,
    input  logic [7:0]            fifo_data_out,
    output logic                  fifo_pop,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [15:0]           ram_data,
    output logic                  busy,
    output logic                  frame_done
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_POP_HI   = 3'd1,
        S_LATCH_HI = 3'd2,
        S_POP_LO   = 3'd3,
        S_LATCH_LO = 3'd4,
        S_WRITE    = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_PIXELS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            hi_q, hi_d;
    logic [7:0]            lo_q, lo_d;
    logic                  frame_done_q, frame_done_d;

    // Next-state, address and byte-capture logic; clear overrides everything.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        frame_done_d = 1'b0;
        if (clear) begin
            state_d = S_IDLE;
            addr_d  = ADDR_ZERO;
            hi_d    = 8'h00;
            lo_d    = 8'h00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) state_d = S_POP_HI;
                    else       state_d = S_IDLE;
                end
                S_POP_HI: begin
                    if (!fifo_empty) state_d = S_LATCH_HI;
                    else             state_d = S_POP_HI;
                end
                S_LATCH_HI: begin
                    hi_d    = fifo_data_out;
                    state_d = S_POP_LO;
                end
                S_POP_LO: begin
                    if (!fifo_empty) state_d = S_LATCH_LO;
                    else             state_d = S_POP_LO;
                end
                S_LATCH_LO: begin
                    lo_d    = fifo_data_out;
                    state_d = S_WRITE;
                end
                S_WRITE: begin
                    if (addr_q == LAST_ADDR) begin
                        addr_d       = ADDR_ZERO;
                        frame_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        addr_d  = addr_q + ADDR_ONE;
                        state_d = S_POP_HI;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    addr_d  = ADDR_ZERO;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge SCLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            addr_q       <= ADDR_ZERO;
            hi_q         <= 8'h00;
            lo_q         <= 8'h00;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Pop depends only on state and FIFO status, so a pop lands in the same cycle it is seen.
    assign fifo_pop   = ((state_q == S_POP_HI) || (state_q == S_POP_LO)) && !fifo_empty;
    assign ram_we     = (state_q == S_WRITE);
    assign ram_addr   = addr_q;
    assign ram_data   = {hi_q, lo_q};
    assign busy       = (state_q != S_IDLE);
    assign frame_done = frame_done_q;

endmodule
